// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side byte buffer behind the UART receiver. Each
//               single-cycle rx_valid strobe is captured with its error flag
//               into a first-word-fall-through FIFO. The CPU drains the FIFO
//               over a valid/ready handshake. Bytes lost to a full FIFO raise
//               a sticky overflow flag. Errored frames are counted in a
//               saturating counter.
// Ports       : clk_576KHz      - system clock, same domain as rx_valid
//               rst             - asynchronous active-high reset
//               rx_valid/rx_data/rx_error - received frame strobe and payload
//               drop_errored    - count errored bytes but do not store them
//               m_valid/m_data/m_error/m_ready - CPU read handshake (FWFT)
//               count/full      - occupancy, registered / pointer compare
//               overflow        - sticky lost-byte flag, cleared by clear_overflow
//               err_count       - saturating errored-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 8
) (
    input  logic                     clk_576KHz,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_error,
    input  logic                     drop_errored,
    output logic                     m_valid,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_error,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [CNT_W-1:0]         err_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    // Storage: each entry is {error, data}.
    logic [DATA_WIDTH:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_PTR_W-1:0]       r_count;
    logic                     r_overflow;
    logic [CNT_W-1:0]         r_err_count;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_push_req;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_ovf_set;
    logic                     w_err_inc;
    logic [DATA_WIDTH:0]      w_head;

    // The extra pointer MSB distinguishes full (same slot, different lap)
    // from empty (same slot, same lap).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

    assign w_push_req = rx_valid && !(drop_errored && rx_error);
    assign w_pop      = !w_empty && m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_err_inc  = rx_valid && rx_error && (r_err_count != {CNT_W{1'b1}});

    // When full, the write slot equals the head slot; the head is read
    // combinationally before the edge, so overwriting it on push+pop is safe.
    always_ff @(posedge clk_576KHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {rx_error, rx_data};
        end
    end

    always_ff @(posedge clk_576KHz or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_PTR_W'(1);
                2'b01:   r_count <= r_count - c_PTR_W'(1);
                default: r_count <= r_count;
            endcase

            // Set has priority over a coincident clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end

            if (w_err_inc) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    // Head outputs are forced to zero while empty so stale entries never show.
    assign m_valid   = !w_empty;
    assign m_data    = w_empty ? '0   : w_head[DATA_WIDTH-1:0];
    assign m_error   = w_empty ? 1'b0 : w_head[DATA_WIDTH];
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A queue-level reference
//               model tracks accepted bytes, overflow and the errored-frame
//               count; accepted bytes go to a scoreboard queue that a monitor
//               pops on each CPU handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rx_valid;
    logic [DW-1:0]           rx_data;
    logic                    rx_error;
    logic                    drop_errored;
    logic                    m_valid;
    logic [DW-1:0]           m_data;
    logic                    m_error;
    logic                    m_ready;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    overflow;
    logic                    clear_overflow;
    logic [CNT_W-1:0]        err_count;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_576KHz     (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_error       (rx_error),
        .drop_errored   (drop_errored),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_error        (m_error),
        .m_ready        (m_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Reference model state: stored entries {err,data}, sticky overflow, error count.
    logic [DW:0] mdl_q[$];
    logic [DW:0] exp_q[$];
    int          mdl_ovf;
    int          mdl_err;
    bit          m_pop;
    bit          m_preq;
    bit          m_accept;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with capacity DEPTH.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_q.delete();
            exp_q.delete();
            mdl_ovf = 0;
            mdl_err = 0;
        end else begin
            m_pop  = (mdl_q.size() > 0) && m_ready;
            m_preq = rx_valid && !(drop_errored && rx_error);
            if (m_pop) void'(mdl_q.pop_front());
            m_accept = m_preq && (mdl_q.size() < DEPTH);
            if (m_accept) begin
                mdl_q.push_back({rx_error, rx_data});
                exp_q.push_back({rx_error, rx_data});
            end
            if (m_preq && !m_accept) mdl_ovf = 1;
            else if (clear_overflow) mdl_ovf = 0;
            if (rx_valid && rx_error && mdl_err < ERR_MAX) mdl_err++;
        end
    end

    // Monitor: status every cycle, head contents vs scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(mdl_q.size()));
            chk("full", 32'(full), 32'(mdl_q.size() == DEPTH));
            chk("m_valid", 32'(m_valid), 32'(mdl_q.size() != 0));
            chk("overflow", 32'(overflow), 32'(mdl_ovf));
            chk("err_count", 32'(err_count), 32'(mdl_err));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("head_unexpected", 32'(m_valid), 32'(0));
                end else begin
                    chk("head_data", 32'(m_data), 32'(exp_q[0][DW-1:0]));
                    chk("head_err", 32'(m_error), 32'(exp_q[0][DW]));
                    if (m_ready && !rst) void'(exp_q.pop_front());
                end
            end else begin
                chk("empty_head", {23'd0, m_error, m_data}, 32'd0);
            end
        end
    end

    task automatic step(input bit v, input logic [DW-1:0] d, input bit e);
        rx_valid = v;
        rx_data  = d;
        rx_error = e;
        @(posedge clk);
        #1;
        rx_valid       = 1'b0;
        rx_error       = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 0; rx_data = '0; rx_error = 0;
        drop_errored = 0; m_ready = 0; clear_overflow = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_errcnt", 32'(err_count), 0);

        // In-order delivery with delayed ready.
        step(1, 8'h55, 0); step(1, 8'hA3, 0); step(1, 8'h0F, 0);
        chk("t1_count", 32'(count), 3);
        chk("t1_head", 32'(m_data), 32'h55);
        m_ready = 1;
        chk("t1_d0", 32'(m_data), 32'h55); idle(1);
        chk("t1_d1", 32'(m_data), 32'hA3); idle(1);
        chk("t1_d2", 32'(m_data), 32'h0F); idle(1);
        chk("t1_empty", 32'(m_valid), 0);
        chk("t1_cnt0", 32'(count), 0);
        m_ready = 0;

        // Fill past capacity: ninth byte is lost.
        for (int i = 1; i <= 9; i++) begin
            step(1, 8'(i), 0);
            if (i == 8) chk("t2_full", 32'(full), 1);
            if (i == 8) chk("t2_noovf", 32'(overflow), 0);
        end
        chk("t2_ovf", 32'(overflow), 1);
        m_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("t2_drain", 32'(m_data), 32'(i));
            idle(1);
        end
        m_ready = 0;
        chk("t2_empty", 32'(m_valid), 0);
        clear_overflow = 1; idle(1);
        chk("t2_clr", 32'(overflow), 0);

        // Push while full with a coincident pop.
        for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0);
        m_ready = 1;
        step(1, 8'hEE, 0);
        m_ready = 0;
        chk("t3_ovf", 32'(overflow), 0);
        chk("t3_count", 32'(count), 8);
        m_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", 32'(m_data), (i < 7) ? 32'(8'h31 + i) : 32'hEE);
            idle(1);
        end
        m_ready = 0;

        // Dropping errored bytes.
        drop_errored = 1;
        step(1, 8'h11, 0); step(1, 8'h22, 1); step(1, 8'h33, 0);
        chk("t4_count", 32'(count), 2);
        chk("t4_errcnt", 32'(err_count), 1);
        drop_errored = 0;
        step(1, 8'h22, 1);
        chk("t4_count2", 32'(count), 3);
        m_ready = 1;
        chk("t4_d0", {m_error, m_data}, 32'h011); idle(1);
        chk("t4_d1", {m_error, m_data}, 32'h033); idle(1);
        chk("t4_d2", {m_error, m_data}, 32'h122); idle(1);
        m_ready = 0;

        // Reset mid-operation with 5 entries and overflow set.
        for (int i = 0; i < 9; i++) step(1, 8'(8'h40 + i), 0);
        m_ready = 1; idle(3); m_ready = 0;
        chk("t5_pre_count", 32'(count), 5);
        chk("t5_pre_ovf", 32'(overflow), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_valid", 32'(m_valid), 0);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_errcnt", 32'(err_count), 0);
        rst = 1'b0;
        step(1, 8'h7E, 0);
        chk("t5_head", 32'(m_data), 32'h7E);
        chk("t5_hvalid", 32'(m_valid), 1);
        m_ready = 1; idle(1); m_ready = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            m_ready        = ($urandom_range(0, 1) == 1);
            drop_errored   = ($urandom_range(0, 9) == 0);
            clear_overflow = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
        end
        m_ready = 1; drop_errored = 0; idle(10);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) step(1, 8'($urandom), 1);
        chk("t6_sat", 32'(err_count), 32'(ERR_MAX));
        idle(5);
        chk("t6_hold", 32'(err_count), 32'(ERR_MAX));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
